// File: rtl/equ_check_seq_pkg.sv
// ----------------------------------------------------------------------------
// equ_check_seq_pkg
//   Shared definitions for the sequential equality checker family:
//   controller state encoding, comparator slice width, and a helper that
//   sizes slice-index fields.
// ----------------------------------------------------------------------------
package equ_check_seq_pkg;

    // Controller states; encodings are fixed so other checkers in this
    // family decode them identically.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of the shared comparator slice.
    localparam int SLICE_W = 2;

    // Width of an index able to address nslice slices, never less than 1.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/equ_check_seq_equcheck2.sv
// ----------------------------------------------------------------------------
// equCheck2
//   Combinational 2-bit equality slice, time-shared by equ_check_seq.
//   Ports:
//     a, b : 2-bit operand slices
//     z    : 1 when a == b
// ----------------------------------------------------------------------------
module equCheck2
    import equ_check_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               z
);

    assign z = (a == b);

endmodule

// File: rtl/equ_check_seq.sv
// ----------------------------------------------------------------------------
// equ_check_seq
//   Sequential wide-word equality checker. Captures two WIDTH-bit operands on
//   an accepted start, then walks one 2-bit slice per clock (LSB slice first)
//   through a single equCheck2, stopping at the first mismatching slice.
//   WIDTH must be even and at least 2.
//   Ports:
//     clk          : system clock, rising edge
//     rst          : synchronous active-high reset
//     start        : request, sampled only while idle
//     a, b         : operands, captured on accepted start
//     busy         : high while a comparison is in progress
//     done         : one-cycle completion pulse
//     equal        : result of last completed comparison (1 = match)
//     mismatch_idx : first mismatching slice of last comparison, 0 if equal
// ----------------------------------------------------------------------------
module equ_check_seq
    import equ_check_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [WIDTH-1:0]                        a,
    input  logic [WIDTH-1:0]                        b,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    equal,
    output logic [idx_width(WIDTH/SLICE_W)-1:0]     mismatch_idx
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [SLICE_W-1:0]   a_slice;
    logic [SLICE_W-1:0]   b_slice;
    logic                 slice_eq;

    // Operand capture. These are pure data registers: their content only
    // matters while RUN, and RUN is always entered through a capture.
    // NOTE: datapath registers are deliberately left out of reset; only
    // control state needs a defined value, and omitting the reset keeps the
    // capture a plain enabled flop.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Slice mux: indexed part-select into the captured operands.
    assign a_slice = a_q[SLICE_W*idx +: SLICE_W];
    assign b_slice = b_q[SLICE_W*idx +: SLICE_W];

    equCheck2 u_cmp (
        .a (a_slice),
        .b (b_slice),
        .z (slice_eq)
    );

    // Controller with registered outputs.
    // NOTE: every register here uses non-blocking assignment so all updates
    // take effect together at the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            equal        <= 1'b0;
            mismatch_idx <= '0;
            idx          <= '0;
        end else begin
            // done is a single-cycle pulse unless a completion re-asserts it.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!slice_eq) begin
                        equal        <= 1'b0;
                        mismatch_idx <= idx;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        equal        <= 1'b1;
                        mismatch_idx <= '0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
